irq_pend_ctrl_4: RTL and testbench

// - 4-line request capture and sequencing stage feeding the 4:2 priority encoder.
// - Captures request events into sticky pending bits, applies a mask, and picks the winner by priority.
// - Presents one winner at a time on a registered valid/ack handshake to the downstream consumer.
// - Sits between raw request sources and the handler that services encoded ids.

---
 rtl/irq_pend_ctrl_4_pkg.sv | 31 +++
 rtl/irq_pend_ctrl_4_if.sv | 24 ++
 rtl/irq_pend_ctrl_4_prio_enc_4.sv | 20 ++
 rtl/irq_pend_ctrl_4.sv | 82 ++++++++
 tb/tb_irq_pend_ctrl_4.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/irq_pend_ctrl_4_pkg.sv
// Shared widths, id encoding and presentation states for the 4-line request controller.
package irq_pend_ctrl_4_pkg;

    localparam int ID_W  = 2;
    localparam int N_REQ = 4;

    // Line 0 carries the highest code so that it reads as the most urgent id downstream.
    localparam logic [ID_W-1:0] ID_B0 = 2'b11;
    localparam logic [ID_W-1:0] ID_B1 = 2'b10;
    localparam logic [ID_W-1:0] ID_B2 = 2'b01;
    localparam logic [ID_W-1:0] ID_B3 = 2'b00;

    typedef enum logic {
        ST_IDLE,
        ST_PRESENT
    } state_t;

    function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] onehot;
        onehot = '0;
        case (id)
            ID_B0:   onehot = 4'b0001;
            ID_B1:   onehot = 4'b0010;
            ID_B2:   onehot = 4'b0100;
            ID_B3:   onehot = 4'b1000;
            default: onehot = '0;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/irq_pend_ctrl_4_if.sv
// Request-side and handler-side signals of the pending controller, bundled as one interface.
interface irq_pend_ctrl_4_if;
    import irq_pend_ctrl_4_pkg::*;

    logic [N_REQ-1:0] req_in;
    logic [N_REQ-1:0] mask;
    logic             irq_ack;
    logic [N_REQ-1:0] ovf_clr;
    logic             irq_valid;
    logic [ID_W-1:0]  irq_id;
    logic [N_REQ-1:0] pend_o;
    logic [N_REQ-1:0] ovf;

    modport master (
        output req_in, mask, irq_ack, ovf_clr,
        input  irq_valid, irq_id, pend_o, ovf
    );

    modport slave (
        input  req_in, mask, irq_ack, ovf_clr,
        output irq_valid, irq_id, pend_o, ovf
    );

endinterface

// File: rtl/irq_pend_ctrl_4_prio_enc_4.sv
// Combinational 4->2 priority encoder; bit 0 wins, any_o flags a non-empty input.
module prio_enc_4
    import irq_pend_ctrl_4_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    output logic [ID_W-1:0]  id,
    output logic             any_o
);

    // NOTE: every output gets a default first so no path through the chain infers a latch.
    always_comb begin
        id    = ID_B3;
        any_o = |req;
        if      (req[0]) id = ID_B0;
        else if (req[1]) id = ID_B1;
        else if (req[2]) id = ID_B2;
        else if (req[3]) id = ID_B3;
    end

endmodule

// File: rtl/irq_pend_ctrl_4.sv
// Sticky request capture, masking and one-at-a-time presentation of the winning id.
module irq_pend_ctrl_4
    import irq_pend_ctrl_4_pkg::*;
#(
    parameter bit EDGE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    irq_pend_ctrl_4_if.slave  bus
);

    logic [N_REQ-1:0] ev;
    logic [N_REQ-1:0] pend;
    logic [N_REQ-1:0] ovf;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] cand;
    logic [ID_W-1:0]  enc_id;
    logic             enc_any;
    state_t           state, state_next;
    logic [ID_W-1:0]  id_q, id_next;

    if (EDGE) begin : g_edge
        logic [N_REQ-1:0] req_q;
        // Reset to all-ones so a line already high at reset release is not seen as an edge.
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk) begin
            if (!rst_n) req_q <= '1;
            else        req_q <= bus.req_in;
        end
        assign ev = bus.req_in & ~req_q;
    end else begin : g_level
        assign ev = bus.req_in;
    end

    assign clr  = (state == ST_PRESENT && bus.irq_ack) ? id_to_onehot(id_q) : '0;
    assign cand = pend & bus.mask;

    prio_enc_4 u_enc (
        .req   (cand),
        .id    (enc_id),
        .any_o (enc_any)
    );

    // The presented id is frozen while PRESENT; only an ack returns to IDLE.
    always_comb begin
        state_next = state;
        id_next    = id_q;
        unique case (state)
            ST_IDLE: begin
                if (enc_any) begin
                    state_next = ST_PRESENT;
                    id_next    = enc_id;
                end
            end
            ST_PRESENT: begin
                if (bus.irq_ack) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            id_q  <= ID_B3;
            pend  <= '0;
            ovf   <= '0;
        end else begin
            state <= state_next;
            id_q  <= id_next;
            // A new event on a line being cleared keeps it pending.
            pend  <= ev | (pend & ~clr);
            ovf   <= EDGE ? ((ev & pend & ~clr) | (ovf & ~bus.ovf_clr)) : '0;
        end
    end

    assign bus.irq_valid = (state == ST_PRESENT);
    assign bus.irq_id    = id_q;
    assign bus.pend_o    = pend;
    assign bus.ovf       = ovf;

endmodule

// File: tb/tb_irq_pend_ctrl_4.sv
// Directed bench for irq_pend_ctrl_4: edge-mode instance plus a level-mode instance.
module tb_irq_pend_ctrl_4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    irq_pend_ctrl_4_if bus ();
    irq_pend_ctrl_4_if lvl ();

    irq_pend_ctrl_4 #(.EDGE(1'b1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    irq_pend_ctrl_4 #(.EDGE(1'b0)) u_dut_lvl (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (lvl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_in = 4'b1111; bus.mask = 4'b1111; bus.irq_ack = 1'b0; bus.ovf_clr = 4'b0000;
        lvl.req_in = 4'b0000; lvl.mask = 4'b1111; lvl.irq_ack = 1'b0; lvl.ovf_clr = 4'b0000;
        tick();
        tick();
        n_cmp++; if (bus.pend_o !== 4'b0000) begin n_err++; $display("FAIL reset_pend: got %b want 0000", bus.pend_o); end
        n_cmp++; if (bus.irq_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.irq_valid); end
        n_cmp++; if (bus.irq_id !== 2'b00) begin n_err++; $display("FAIL reset_id: got %b want 00", bus.irq_id); end
        n_cmp++; if (bus.ovf !== 4'b0000) begin n_err++; $display("FAIL reset_ovf: got %b want 0000", bus.ovf); end
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.pend_o !== 4'b0000) begin n_err++; $display("FAIL reset_no_event_pend: got %b want 0000", bus.pend_o); end
        n_cmp++; if (bus.irq_valid !== 1'b0) begin n_err++; $display("FAIL reset_no_event_valid: got %b want 0", bus.irq_valid); end
        bus.req_in = 4'b0000;
        tick();
    endtask

    task automatic test_single_event();
        bus.req_in = 4'b0100;
        tick();
        n_cmp++; if (bus.pend_o !== 4'b0100) begin n_err++; $display("FAIL single_pend: got %b want 0100", bus.pend_o); end
        n_cmp++; if (bus.irq_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_k: got %b want 0", bus.irq_valid); end
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b1) begin n_err++; $display("FAIL single_valid_k1: got %b want 1", bus.irq_valid); end
        n_cmp++; if (bus.irq_id !== 2'b01) begin n_err++; $display("FAIL single_id: got %b want 01", bus.irq_id); end
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        n_cmp++; if (bus.pend_o !== 4'b0000) begin n_err++; $display("FAIL single_ack_pend: got %b want 0000", bus.pend_o); end
        n_cmp++; if (bus.irq_valid !== 1'b0) begin n_err++; $display("FAIL single_ack_valid: got %b want 0", bus.irq_valid); end
        bus.req_in = 4'b0000;
        tick();
    endtask

    task automatic test_priority_stability();
        bus.req_in = 4'b1000;
        tick();
        tick();
        n_cmp++; if (bus.irq_id !== 2'b00) begin n_err++; $display("FAIL prio_first_id: got %b want 00", bus.irq_id); end
        bus.req_in = 4'b1001;
        tick();
        n_cmp++; if (bus.pend_o !== 4'b1001) begin n_err++; $display("FAIL prio_pend: got %b want 1001", bus.pend_o); end
        n_cmp++; if (bus.irq_id !== 2'b00) begin n_err++; $display("FAIL prio_frozen_id: got %b want 00", bus.irq_id); end
        tick();
        n_cmp++; if (bus.irq_id !== 2'b00 || bus.irq_valid !== 1'b1) begin n_err++; $display("FAIL prio_frozen_id2: got v=%b id=%b want v=1 id=00", bus.irq_valid, bus.irq_id); end
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        n_cmp++; if (bus.pend_o !== 4'b0001) begin n_err++; $display("FAIL prio_ack_pend: got %b want 0001", bus.pend_o); end
        n_cmp++; if (bus.irq_valid !== 1'b0) begin n_err++; $display("FAIL prio_bubble: got %b want 0", bus.irq_valid); end
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'b11) begin n_err++; $display("FAIL prio_next_id: got v=%b id=%b want v=1 id=11", bus.irq_valid, bus.irq_id); end
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        n_cmp++; if (bus.pend_o !== 4'b0000) begin n_err++; $display("FAIL prio_drain: got %b want 0000", bus.pend_o); end
        bus.req_in = 4'b0000;
        tick();
    endtask

    task automatic test_masking();
        bus.mask   = 4'b1101;
        bus.req_in = 4'b0010;
        tick();
        n_cmp++; if (bus.pend_o !== 4'b0010) begin n_err++; $display("FAIL mask_pend: got %b want 0010", bus.pend_o); end
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b0) begin n_err++; $display("FAIL mask_hold: got %b want 0", bus.irq_valid); end
        // Stray ack while idle must not disturb the pending bit.
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        n_cmp++; if (bus.pend_o !== 4'b0010) begin n_err++; $display("FAIL mask_idle_ack: got %b want 0010", bus.pend_o); end
        bus.mask = 4'b1111;
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'b10) begin n_err++; $display("FAIL mask_unmask: got v=%b id=%b want v=1 id=10", bus.irq_valid, bus.irq_id); end
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        n_cmp++; if (bus.pend_o !== 4'b0000 || bus.irq_valid !== 1'b0) begin n_err++; $display("FAIL mask_ack: got p=%b v=%b want p=0000 v=0", bus.pend_o, bus.irq_valid); end
        bus.req_in = 4'b0000;
        tick();
    endtask

    task automatic test_set_vs_clear_ovf();
        bus.req_in = 4'b0001;
        tick();
        tick();
        n_cmp++; if (bus.irq_id !== 2'b11 || bus.irq_valid !== 1'b1) begin n_err++; $display("FAIL svc_present: got v=%b id=%b want v=1 id=11", bus.irq_valid, bus.irq_id); end
        bus.req_in = 4'b0000;
        tick();
        bus.req_in  = 4'b0001;
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        n_cmp++; if (bus.pend_o !== 4'b0001) begin n_err++; $display("FAIL svc_set_wins: got %b want 0001", bus.pend_o); end
        n_cmp++; if (bus.ovf !== 4'b0000) begin n_err++; $display("FAIL svc_no_ovf: got %b want 0000", bus.ovf); end
        n_cmp++; if (bus.irq_valid !== 1'b0) begin n_err++; $display("FAIL svc_valid: got %b want 0", bus.irq_valid); end
        bus.req_in = 4'b0000;
        tick();
        bus.req_in = 4'b0001;
        tick();
        n_cmp++; if (bus.ovf !== 4'b0001) begin n_err++; $display("FAIL ovf_set: got %b want 0001", bus.ovf); end
        bus.ovf_clr = 4'b0001;
        tick();
        bus.ovf_clr = 4'b0000;
        n_cmp++; if (bus.ovf !== 4'b0000) begin n_err++; $display("FAIL ovf_clr: got %b want 0000", bus.ovf); end
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        n_cmp++; if (bus.pend_o !== 4'b0000) begin n_err++; $display("FAIL svc_drain: got %b want 0000", bus.pend_o); end
        bus.req_in = 4'b0000;
        tick();
    endtask

    task automatic test_level_mode();
        lvl.req_in = 4'b0001;
        tick();
        n_cmp++; if (lvl.pend_o !== 4'b0001 || lvl.irq_valid !== 1'b0) begin n_err++; $display("FAIL lvl_pend: got p=%b v=%b want p=0001 v=0", lvl.pend_o, lvl.irq_valid); end
        tick();
        for (int r = 0; r < 3; r++) begin
            n_cmp++; if (lvl.irq_valid !== 1'b1 || lvl.irq_id !== 2'b11) begin n_err++; $display("FAIL lvl_present[%0d]: got v=%b id=%b want v=1 id=11", r, lvl.irq_valid, lvl.irq_id); end
            tick();
            n_cmp++; if (lvl.irq_valid !== 1'b1) begin n_err++; $display("FAIL lvl_hold[%0d]: got %b want 1", r, lvl.irq_valid); end
            lvl.irq_ack = 1'b1;
            tick();
            lvl.irq_ack = 1'b0;
            n_cmp++; if (lvl.irq_valid !== 1'b0 || lvl.pend_o !== 4'b0001) begin n_err++; $display("FAIL lvl_bubble[%0d]: got v=%b p=%b want v=0 p=0001", r, lvl.irq_valid, lvl.pend_o); end
            n_cmp++; if (lvl.ovf !== 4'b0000) begin n_err++; $display("FAIL lvl_ovf[%0d]: got %b want 0000", r, lvl.ovf); end
            tick();
        end
        lvl.req_in = 4'b0000;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_event();
        test_priority_stability();
        test_masking();
        test_set_vs_clear_ovf();
        test_level_mode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
